fifo_out_ctrl: RTL and testbench



---
 rtl/fifo_out_ctrl_if.sv | 22 ++
 rtl/fifo_out_ctrl.sv | 119 +++++++++++
 tb/tb_fifo_out_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_out_ctrl_if.sv
// Drain-side handshake between the weight FIFO bank, the drain controller and the PE array.
interface fifo_out_ctrl_if #(
    parameter int FIFO_WIDTH = 16
);
    logic                  start;
    logic [FIFO_WIDTH-1:0] fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_rd_en;
    logic [FIFO_WIDTH-1:0] pe_w_valid;
    logic                  busy;
    logic                  done;
    logic                  err_underflow;

    modport master (
        output start, fifo_empty,
        input  fifo_rd_en, pe_w_valid, busy, done, err_underflow
    );

    modport slave (
        input  start, fifo_empty,
        output fifo_rd_en, pe_w_valid, busy, done, err_underflow
    );
endinterface

// File: rtl/fifo_out_ctrl.sv
// Weight FIFO drain controller: pops FIFO_DEPTH entries per column, column i skewed by i cycles,
// with a 1-cycle delayed weight-valid strobe to the PE array.
module fifo_out_col #(
    parameter int IDX        = 0,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CNT_WIDTH-1:0] k_nxt,
    input  logic                 empty,
    output logic                 rd_en,
    output logic                 pe_w_valid,
    output logic                 uflow
);
    localparam int STAGES = 1;
    localparam logic [CNT_WIDTH-1:0] LO = CNT_WIDTH'(IDX + 1);
    localparam logic [CNT_WIDTH-1:0] HI = CNT_WIDTH'(IDX + FIFO_DEPTH);

    logic              hit;
    logic [STAGES:0]   vld_pipe;

    // Window is evaluated on the next count so the pop strobe itself is a flop.
    assign hit = (k_nxt >= LO) && (k_nxt <= HI);

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-1:0], hit};
    end

    assign rd_en      = vld_pipe[0];
    assign pe_w_valid = vld_pipe[1];
    assign uflow      = vld_pipe[0] & empty;
endmodule

module fifo_out_ctrl #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_out_ctrl_if.slave   bus
);
    localparam int CNT_WIDTH = $clog2(FIFO_DEPTH + FIFO_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] K_LAST = CNT_WIDTH'(FIFO_DEPTH + FIFO_WIDTH);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t                 state, state_nxt;
    logic [CNT_WIDTH-1:0]   k, k_nxt;
    logic                   accept;
    logic                   busy_q, done_q, err_q;
    logic [FIFO_WIDTH-1:0]  rd_en, pe_v, uflow;

    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start)   state_nxt = DRAIN;
            DRAIN:   if (k == K_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        k_nxt = '0;
        case (state)
            IDLE:    if (bus.start)   k_nxt = CNT_WIDTH'(1);
            DRAIN:   if (k != K_LAST) k_nxt = k + CNT_WIDTH'(1);
            default: k_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= (k_nxt != '0);
            done_q <= (k_nxt == K_LAST);
            if (accept)      err_q <= 1'b0;
            else if (|uflow) err_q <= 1'b1;
        end
    end

    for (genvar i = 0; i < FIFO_WIDTH; i++) begin : g_col
        fifo_out_col #(
            .IDX        (i),
            .FIFO_DEPTH (FIFO_DEPTH),
            .CNT_WIDTH  (CNT_WIDTH)
        ) u_col (
            .clk        (clk),
            .rst        (rst),
            .k_nxt      (k_nxt),
            .empty      (bus.fifo_empty[i]),
            .rd_en      (rd_en[i]),
            .pe_w_valid (pe_v[i]),
            .uflow      (uflow[i])
        );
    end

    assign bus.fifo_rd_en    = rd_en;
    assign bus.pe_w_valid    = pe_v;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.err_underflow = err_q;
endmodule

// File: tb/tb_fifo_out_ctrl.sv
// Bench for fifo_out_ctrl: 4x4 instance checked cycle-by-cycle via scoreboard, 16x16 instance by pop counts.
module tb_fifo_out_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fifo_out_ctrl_if #(.FIFO_WIDTH(4))  bus4 ();
    fifo_out_ctrl_if #(.FIFO_WIDTH(16)) bus16 ();

    fifo_out_ctrl #(.FIFO_WIDTH(4), .FIFO_DEPTH(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    fifo_out_ctrl #(.FIFO_WIDTH(16), .FIFO_DEPTH(16)) u_dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    typedef struct {
        logic [3:0] rd;
        logic [3:0] pv;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    exp_t sb[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected 4x4 outputs for cycles 1..9 after an accepted start.
    function automatic void push_drain(int uf_col);
        exp_t e;
        for (int c = 1; c <= 9; c++) begin
            for (int i = 0; i < 4; i++) begin
                e.rd[i] = (c >= i + 1) && (c <= i + 4);
                e.pv[i] = (c - 1 >= i + 1) && (c - 1 <= i + 4);
            end
            e.busy = (c <= 8);
            e.done = (c == 8);
            e.err  = (uf_col >= 0) && (c >= uf_col + 2);
            sb.push_back(e);
        end
    endfunction

    task automatic run_sb(input string tag, input int ign_a, input int ign_b);
        exp_t e;
        int   c = 0;
        while (sb.size() > 0) begin
            tick();
            c++;
            e = sb.pop_front();
            checks += 5;
            if (bus4.fifo_rd_en !== e.rd) begin
                errors++;
                $display("FAIL %s rd_en cycle %0d: got %b expected %b", tag, c, bus4.fifo_rd_en, e.rd);
            end
            if (bus4.pe_w_valid !== e.pv) begin
                errors++;
                $display("FAIL %s pe_w_valid cycle %0d: got %b expected %b", tag, c, bus4.pe_w_valid, e.pv);
            end
            if (bus4.busy !== e.busy) begin
                errors++;
                $display("FAIL %s busy cycle %0d: got %b expected %b", tag, c, bus4.busy, e.busy);
            end
            if (bus4.done !== e.done) begin
                errors++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, c, bus4.done, e.done);
            end
            if (bus4.err_underflow !== e.err) begin
                errors++;
                $display("FAIL %s err_underflow cycle %0d: got %b expected %b", tag, c, bus4.err_underflow, e.err);
            end
            bus4.start = (c == ign_a) || (c == ign_b);
        end
        bus4.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks += 2;
        if ({bus4.fifo_rd_en, bus4.pe_w_valid, bus4.busy, bus4.done, bus4.err_underflow} !== 11'b0) begin
            errors++;
            $display("FAIL reset4: got %b expected all zero",
                     {bus4.fifo_rd_en, bus4.pe_w_valid, bus4.busy, bus4.done, bus4.err_underflow});
        end
        if ({bus16.fifo_rd_en, bus16.pe_w_valid, bus16.busy, bus16.done, bus16.err_underflow} !== 35'b0) begin
            errors++;
            $display("FAIL reset16: got %b expected all zero",
                     {bus16.fifo_rd_en, bus16.pe_w_valid, bus16.busy, bus16.done, bus16.err_underflow});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        bus4.start = 1'b1;
        push_drain(-1);
        run_sb("basic", 0, 0);
    endtask

    task automatic test_start_ignored();
        bus4.start = 1'b1;
        push_drain(-1);
        run_sb("ignored", 3, 8);
        bus4.start = 1'b1;
        push_drain(-1);
        run_sb("restart", 0, 0);
    endtask

    task automatic test_underflow();
        bus4.fifo_empty = 4'b0100;
        bus4.start = 1'b1;
        push_drain(2);
        run_sb("underflow", 0, 0);
        bus4.fifo_empty = 4'b0000;
        bus4.start = 1'b1;
        push_drain(-1);
        run_sb("uf_clear", 0, 0);
    endtask

    task automatic test_rst_start();
        rst = 1'b1;
        bus4.start = 1'b1;
        tick();
        rst = 1'b0;
        bus4.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (bus4.busy !== 1'b0 || bus4.fifo_rd_en !== 4'b0) begin
                errors++;
                $display("FAIL rst_start cycle %0d: got busy=%b rd_en=%b expected busy=0 rd_en=0000",
                         c, bus4.busy, bus4.fifo_rd_en);
            end
            tick();
        end
    endtask

    task automatic test_full16(input string tag);
        int cnt[16];
        int first15 = -1;
        int last15  = -1;
        int done_c  = -1;
        int n_done  = 0;
        foreach (cnt[i]) cnt[i] = 0;
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            for (int i = 0; i < 16; i++) if (bus16.fifo_rd_en[i]) cnt[i]++;
            if (bus16.fifo_rd_en[15]) begin
                if (first15 < 0) first15 = c;
                last15 = c;
            end
            if (bus16.done) begin
                done_c = c;
                n_done++;
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (cnt[i] !== 16) begin
                errors++;
                $display("FAIL %s pops col %0d: got %0d expected 16", tag, i, cnt[i]);
            end
        end
        checks += 4;
        if (first15 !== 16) begin
            errors++;
            $display("FAIL %s col15 first pop: got %0d expected 16", tag, first15);
        end
        if (last15 !== 31) begin
            errors++;
            $display("FAIL %s col15 last pop: got %0d expected 31", tag, last15);
        end
        if (done_c !== 32 || n_done !== 1) begin
            errors++;
            $display("FAIL %s done: got cycle %0d count %0d expected cycle 32 count 1", tag, done_c, n_done);
        end
        if (bus16.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after drain: got %b expected 0", tag, bus16.busy);
        end
    endtask

    task automatic test_rst_mid16();
        bus16.start = 1'b1;
        tick();
        bus16.start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 6; c < 12; c++) begin
            checks++;
            if ({bus16.fifo_rd_en, bus16.pe_w_valid, bus16.busy, bus16.done, bus16.err_underflow} !== 35'b0) begin
                errors++;
                $display("FAIL rst_mid16 cycle %0d: got rd_en=%h pe_w_valid=%h busy=%b done=%b err=%b expected all zero",
                         c, bus16.fifo_rd_en, bus16.pe_w_valid, bus16.busy, bus16.done, bus16.err_underflow);
            end
            tick();
        end
        test_full16("after_rst16");
    endtask

    initial begin
        bus4.start       = 1'b0;
        bus4.fifo_empty  = '0;
        bus16.start      = 1'b0;
        bus16.fifo_empty = '0;
        test_reset();
        test_basic();
        test_start_ignored();
        test_underflow();
        test_rst_start();
        test_full16("full16");
        test_rst_mid16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
